// File: rtl/tone_sequencer_if.sv
// Bus bundle between the CPU-side Avalon-MM slave, the tone generator write port
// and the sequencer status/debug outputs.
interface tone_sequencer_if;
    // Handshake: s_write/s_read are single-cycle qualifiers that are always accepted
    // (no waitrequest); s_readdata is valid the cycle after s_read and held until the
    // next read; tg_write is a one-cycle strobe qualifying tg_writedata, which holds.
    logic [1:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_read;
    logic [31:0] s_readdata;
    logic [31:0] tg_writedata;
    logic        tg_write;
    logic        busy;
    logic        done;
    logic [2:0]  fsm_state;

    modport master (
        output s_address, s_write, s_writedata, s_read,
        input  s_readdata, tg_writedata, tg_write, busy, done, fsm_state
    );

    modport slave (
        input  s_address, s_write, s_writedata, s_read,
        output s_readdata, tg_writedata, tg_write, busy, done, fsm_state
    );
endinterface

// File: rtl/tone_sequencer.sv
// Autonomous note player: plays a CPU-loaded (frequency, duration) table into a
// tone generator, with a silent gap between notes and optional looping.
module tone_sequencer #(
    parameter int FCLK   = 50_000_000,
    parameter int DEPTH  = 16,
    parameter int GAP_MS = 10
) (
    input logic             clk,
    input logic             reset_n,
    tone_sequencer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [31:0]   TICKS       = 32'(FCLK / 1000);
    localparam logic [31:0]   PRESC_START = (TICKS > 32'd1) ? 32'd1 : 32'd0;
    localparam logic [15:0]   GAP_T       = 16'(GAP_MS);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NOTE = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_SIL  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          loop_q, loop_d;
    logic [31:0]   presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic          done_q, done_d;
    logic          stop_wr_q, stop_wr_d;
    logic [31:0]   last_q, last_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [15:0] freq_q [DEPTH];
    logic [15:0] dur_q  [DEPTH];

    logic          ctrl_wr, start_cmd, stop_cmd, push_cmd, clear_cmd, push_ok;
    logic          busy, tick, advance, wr_en;
    logic [31:0]   wr_data, tg_data_c, status;
    logic [15:0]   cur_freq, cur_dur, ms_inc;
    logic [CW-1:0] idx_next;

    // Stop has priority over start when both bits arrive in one CTRL write.
    assign ctrl_wr   = bus.s_write && (bus.s_address == 2'd0);
    assign stop_cmd  = ctrl_wr && bus.s_writedata[2];
    assign start_cmd = ctrl_wr && bus.s_writedata[0] && !bus.s_writedata[2];
    assign push_cmd  = bus.s_write && (bus.s_address == 2'd2);
    assign clear_cmd = bus.s_write && (bus.s_address == 2'd3);
    assign push_ok   = push_cmd && (count_q != DEPTH_C);

    assign busy     = (state_q != S_IDLE);
    assign tick     = (presc_q == TICKS - 32'd1);
    assign cur_freq = freq_q[idx_q];
    assign cur_dur  = dur_q[idx_q];
    assign ms_inc   = ms_q + 16'd1;
    assign idx_next = CW'(idx_q) + CW'(1);

    // The NOTE/SIL cycle counts as the first cycle of the following interval, so the
    // prescaler restarts at 1 and the interval spans exactly ms*TICKS cycles.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loop_d    = loop_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        done_d    = 1'b0;
        stop_wr_d = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 32'd0;
        advance   = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = 32'd0;
                ms_d    = 16'd0;
                if (start_cmd) begin
                    if (count_q != '0) begin
                        idx_d   = '0;
                        loop_d  = bus.s_writedata[1];
                        state_d = S_NOTE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_NOTE: begin
                if (cur_dur == 16'd0) begin
                    advance = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = {16'd0, cur_freq};
                    presc_d = PRESC_START;
                    ms_d    = 16'd0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    presc_d = 32'd0;
                    if (ms_inc >= cur_dur) state_d = S_SIL;
                    else                   ms_d    = ms_inc;
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            S_SIL: begin
                wr_en = 1'b1;
                if (GAP_T == 16'd0) begin
                    advance = 1'b1;
                end else begin
                    presc_d = PRESC_START;
                    ms_d    = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    presc_d = 32'd0;
                    if (ms_inc >= GAP_T) advance = 1'b1;
                    else                 ms_d    = ms_inc;
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_next < count_q) begin
                idx_d   = idx_next[IW-1:0];
                state_d = S_NOTE;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = S_NOTE;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (busy && stop_cmd) begin
            state_d   = S_IDLE;
            stop_wr_d = 1'b1;
            done_d    = 1'b0;
        end
    end

    // Table bookkeeping: pushes append even while playing, clear only when idle.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_cmd) begin
            if (push_ok) count_d = count_q + CW'(1);
            else         ovf_d   = 1'b1;
        end else if (clear_cmd && !busy) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    assign status    = {8'd0, 8'(idx_q), 3'd0, 9'(count_q), 2'd0, ovf_q, busy};
    assign tg_data_c = wr_en ? wr_data : (stop_wr_q ? 32'd0 : last_q);
    assign last_d    = tg_data_c;

    always_comb begin
        rdata_d = rdata_q;
        if (bus.s_read) rdata_d = (bus.s_address == 2'd1) ? status : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            loop_q    <= 1'b0;
            presc_q   <= 32'd0;
            ms_q      <= 16'd0;
            done_q    <= 1'b0;
            stop_wr_q <= 1'b0;
            last_q    <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            loop_q    <= loop_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
            done_q    <= done_d;
            stop_wr_q <= stop_wr_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            freq_q[count_q[IW-1:0]] <= bus.s_writedata[15:0];
            dur_q[count_q[IW-1:0]]  <= bus.s_writedata[31:16];
        end
    end

    assign bus.s_readdata   = rdata_q;
    assign bus.tg_writedata = tg_data_c;
    assign bus.tg_write     = wr_en || stop_wr_q;
    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenarios plus random note tables
// compared against a timeline model of the playback rules.
module tb_tone_sequencer;
    localparam int FCLK   = 10000;
    localparam int DEPTH  = 4;
    localparam int GAP_MS = 1;
    localparam int TPM    = FCLK / 1000;
    localparam int NOLIM  = 1 << 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tone_sequencer_if bus();

    tone_sequencer #(.FCLK(FCLK), .DEPTH(DEPTH), .GAP_MS(GAP_MS)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [31:0] d; } ev_t;
    ev_t  wr_log[$];
    int   done_log[$];
    logic done_busy[$];

    always @(negedge clk) begin
        ev_t e;
        if (bus.tg_write) begin
            e.t = cyc;
            e.d = bus.tg_writedata;
            wr_log.push_back(e);
        end
        if (bus.done) begin
            done_log.push_back(cyc);
            done_busy.push_back(bus.busy);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the note table as queues and a timeline of expected events.
    logic [15:0] m_f[$], m_d[$];
    logic        m_ovf;
    int          exp_t[$];
    logic [31:0] exp_q[$];
    int          exp_done[$];

    task automatic model_clear();
        m_f.delete();
        m_d.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] f, input logic [15:0] d);
        if (m_f.size() < DEPTH) begin
            m_f.push_back(f);
            m_d.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_play(input int c0, input bit lp, input int limit);
        int t;
        t = c0;
        exp_t.delete();
        exp_q.delete();
        exp_done.delete();
        if (m_f.size() == 0) begin
            exp_done.push_back(t);
            return;
        end
        forever begin
            for (int i = 0; i < m_f.size(); i++) begin
                if (t > limit) return;
                if (m_d[i] == 16'd0) begin
                    t += 1;
                end else begin
                    exp_t.push_back(t);
                    exp_q.push_back({16'd0, m_f[i]});
                    t += int'(m_d[i]) * TPM;
                    if (t <= limit) begin
                        exp_t.push_back(t);
                        exp_q.push_back(32'd0);
                    end
                    t += GAP_MS * TPM;
                end
            end
            if (!lp) begin
                exp_done.push_back(t);
                return;
            end
        end
    endtask

    int cmd_cyc;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.s_address   = a;
        bus.s_write     = 1'b1;
        bus.s_writedata = d;
        cmd_cyc         = cyc;
        @(posedge clk); #1;
        bus.s_write     = 1'b0;
        bus.s_writedata = 32'd0;
        bus.s_address   = 2'd0;
    endtask

    task automatic push(input logic [15:0] f, input logic [15:0] d);
        bus_write(2'd2, {d, f});
        model_push(f, d);
    endtask

    task automatic clear_table();
        bus_write(2'd3, 32'd0);
        model_clear();
    endtask

    task automatic read_status(output logic [31:0] st);
        @(posedge clk); #1;
        bus.s_address = 2'd1;
        bus.s_read    = 1'b1;
        @(posedge clk); #1;
        bus.s_read    = 1'b0;
        bus.s_address = 2'd0;
        st = bus.s_readdata;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
        done_busy.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_log.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_t.size());
        for (int i = 0; i < wr_log.size() && i < exp_t.size(); i++) begin
            check($sformatf("%s_t%0d", tag, i), wr_log[i].t, exp_t[i]);
            check($sformatf("%s_d%0d", tag, i), wr_log[i].d, exp_q[i]);
        end
        check({tag, "_ndone"}, done_log.size(), exp_done.size());
        for (int i = 0; i < done_log.size() && i < exp_done.size(); i++) begin
            check($sformatf("%s_done_t%0d", tag, i), done_log[i], exp_done[i]);
            check($sformatf("%s_done_busy%0d", tag, i), done_busy[i], 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        int c0, n, wait_n;

        bus.s_address = 2'd0; bus.s_write = 1'b0; bus.s_writedata = 32'd0; bus.s_read = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tg_write", bus.tg_write, 0);
        check("rst_tg_data", bus.tg_writedata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rdata", bus.s_readdata, 0);
        reset_n = 1'b1;
        read_status(st);
        check("rst_status", st, 0);

        // Two-note sequence with known timing.
        clear_table();
        push(16'd440, 16'd2);
        push(16'd880, 16'd1);
        clear_logs();
        bus_write(2'd0, 32'd1);
        model_play(cmd_cyc + 1, 1'b0, NOLIM);
        wait_done(500);
        compare_run("seq");
        check("seq_strobes", wr_log.size(), 4);

        // Overflow and clear.
        clear_table();
        for (int i = 0; i < 5; i++) push(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 3)));
        read_status(st);
        check("ovf_count", st[12:4], m_f.size());
        check("ovf_flag", st[1], m_ovf);
        clear_table();
        read_status(st);
        check("clr_count", st[12:4], 0);
        check("clr_flag", st[1], 0);

        // Random tables, including zero-duration entries.
        repeat (6) begin
            clear_table();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push(16'($urandom_range(1, 65535)), 16'($urandom_range(0, 3)));
            clear_logs();
            bus_write(2'd0, 32'd1);
            model_play(cmd_cyc + 1, 1'b0, NOLIM);
            wait_done(1000);
            compare_run("rnd");
        end

        // Zero-duration entry between two notes.
        clear_table();
        push(16'd500, 16'd1);
        push(16'd600, 16'd0);
        push(16'd700, 16'd1);
        clear_logs();
        bus_write(2'd0, 32'd1);
        model_play(cmd_cyc + 1, 1'b0, NOLIM);
        wait_done(500);
        compare_run("skip");

        // Looped single note, then stop part-way through a hold.
        clear_table();
        push(16'd1000, 16'd1);
        clear_logs();
        bus_write(2'd0, 32'd3);
        c0 = cmd_cyc + 1;
        wait_n = 0;
        while (wr_log.size() < 7 && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (2) @(negedge clk);
        bus_write(2'd0, 32'd4);
        check("stop_tg_write", bus.tg_write, 1);
        check("stop_tg_data", bus.tg_writedata, 0);
        check("stop_busy", bus.busy, 0);
        model_play(c0, 1'b1, cmd_cyc);
        exp_t.push_back(cmd_cyc + 1);
        exp_q.push_back(32'd0);
        repeat (30) @(negedge clk);
        compare_run("loop");

        // Start with an empty table.
        clear_table();
        clear_logs();
        bus_write(2'd0, 32'd1);
        model_play(cmd_cyc + 1, 1'b0, NOLIM);
        wait_done(100);
        compare_run("empty");

        // Asynchronous reset in the middle of a hold.
        clear_table();
        push(16'd1234, 16'd5);
        clear_logs();
        bus_write(2'd0, 32'd1);
        wait_n = 0;
        while (wr_log.size() < 1 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tg_write", bus.tg_write, 0);
        check("arst_tg_data", bus.tg_writedata, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_rdata", bus.s_readdata, 0);
        clear_logs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("arst_nowr", wr_log.size(), 0);
        model_clear();
        read_status(st);
        check("arst_status", st, 0);
        clear_logs();
        bus_write(2'd0, 32'd1);
        model_play(cmd_cyc + 1, 1'b0, NOLIM);
        wait_done(100);
        compare_run("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
